mult_seq_32: RTL and testbench

- Iterative 32x32 multiplier in the EX stage for MULT/MULTU.
- Drives a 32-bit add each iteration (radix-2 shift-add) and writes a 64-bit product to the HI/LO pair.
- Pipeline control holds the instruction stream while busy is high.
- Trades area for latency against a full array multiplier.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_seq_32_step.sv | 23 ++
 rtl/mult_seq_32.sv | 160 ++++++++++++++++
 tb/tb_mult_seq_32.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM state
// encoding, sizing constants and the operand-magnitude helper.
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITER  = 32;
    localparam int MULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    // Magnitude of an operand: negate only for signed ops with the sign bit set.
    // -2^31 maps to 0x8000_0000, which is a valid unsigned magnitude.
    function automatic logic [MULT_WIDTH-1:0] mult_abs(
        input logic [MULT_WIDTH-1:0] x,
        input logic                  is_signed
    );
        if (is_signed && x[MULT_WIDTH-1]) begin
            return ~x + 1'b1;
        end
        return x;
    endfunction

endpackage

// File: rtl/mult_seq_32_step.sv
// One radix-2 shift-add iteration of the sequential multiplier.
// The upper half of the accumulator gains the multiplicand when the
// current multiplier LSB is set; the whole accumulator then shifts right
// with the adder carry entering at the top.
module mult_seq_32_step
    import mult_pkg::*;
(
    input  logic [2*MULT_WIDTH-1:0] acc_i,
    input  logic [MULT_WIDTH-1:0]   mcand_i,
    output logic [2*MULT_WIDTH-1:0] acc_o
);

    logic [MULT_WIDTH:0]   sum33;
    logic [MULT_WIDTH-1:0] addend;

    // Conditional add of the multiplicand, then shift right by one.
    always_comb begin
        addend = acc_i[0] ? mcand_i : '0;
        sum33  = {1'b0, acc_i[2*MULT_WIDTH-1:MULT_WIDTH]} + {1'b0, addend};
        acc_o  = {sum33, acc_i[MULT_WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_seq_32.sv
// Iterative 32x32 MULT/MULTU unit for the EX stage.
// Operands are converted to magnitudes on acceptance, multiplied by 32
// shift-add iterations, then the sign is applied in a single fix-up cycle
// that also writes HI/LO and raises done.
// Optional build macro: MULT_EARLY_OUT_EN -- a zero operand at acceptance
// bypasses RUN/FIX, writes HI/LO = 0 at once and pulses done in cycle 1.
module mult_seq_32
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [MULT_CNT_W-1:0] LAST_COUNT = MULT_CNT_W'(ITER - 1);

    mult_state_e             state_q, state_d;
    logic [MULT_CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]        mcand_q, mcand_d;
    logic                    neg_q, neg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;

    logic [2*WIDTH-1:0]      acc_step;
    logic [2*WIDTH-1:0]      result;
    logic                    zero_op;

    mult_seq_32_step u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_step)
    );

    // Zero-operand detection used only by the early-out path.
    always_comb begin
`ifdef MULT_EARLY_OUT_EN
        zero_op = (a == '0) || (b == '0);
`else
        zero_op = 1'b0;
`endif
    end

    // Apply the sign to the unsigned magnitude product.
    always_comb begin
        result = neg_q ? (~acc_q + 64'd1) : acc_q;
    end

    // Next-state and next-output logic for the multiply sequencer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE so that
            // back-to-back multiplies lose no cycle; flush drops the start.
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start && !flush) begin
                    mcand_d = mult_abs(a, signed_op);
                    acc_d   = {{WIDTH{1'b0}}, mult_abs(b, signed_op)};
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    count_d = '0;
                    if (zero_op) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hi_d    = result[2*WIDTH-1:WIDTH];
                    lo_d    = result[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_32.sv
// Self-checking bench for mult_seq_32: directed scenarios plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_mult_seq_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent operation
    int          obs_lat;
    logic [31:0] obs_hi;
    logic [31:0] obs_lo;
    logic        busy_seen [0:41];

`ifdef MULT_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mult_seq_32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product using plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({32'b0, x}) * longint'({32'b0, y});
        return p;
    endfunction

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
        if (EARLY && (x == 0 || y == 0)) return 1;
        return 34;
    endfunction

    // Number of cycles 1..lat whose busy differs from the expected profile
    function automatic int busy_bad(input int lat, input bit early_path);
        int bad = 0;
        for (int k = 1; k <= lat; k++) begin
            if (busy_seen[k] !== ((k < lat) && !early_path)) bad++;
        end
        return bad;
    endfunction

    // Issue one request (entered just after a negedge) and observe up to maxk cycles.
    task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input int flush_at, input int rst_at, input int junk_at,
                           input int maxk);
        a = x; b = y; signed_op = s; start = 1'b1;
        obs_lat = 0; obs_hi = 'x; obs_lo = 'x;
        for (int i = 0; i <= 41; i++) busy_seen[i] = 1'b0;
        for (int k = 1; k <= maxk; k++) begin
            @(posedge clk);
            @(negedge clk);
            busy_seen[k] = busy;
            if (done === 1'b1 && obs_lat == 0) begin
                obs_lat = k; obs_hi = hi; obs_lo = lo;
            end
            start = (k == junk_at);
            if (k == junk_at) begin a = 32'd9; b = 32'd9; end
            flush = (k == flush_at);
            rst   = (k == rst_at);
            if (obs_lat != 0) break;
        end
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        $display("op a=%08h b=%08h s=%0d lat=%0d hi=%08h lo=%08h", x, y, s, obs_lat, obs_hi, obs_lo);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; signed_op = 1'b0; a = '1; b = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state busy=%0b done=%0b hi=%08h lo=%08h expected all zero",
                     busy, done, hi, lo);
        end
        rst = 1'b0;
        $display("reset: busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    endtask

    task automatic test_unsigned_max();
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34) begin
            n_fail++; $display("FAIL umax_latency got %0d expected 34", obs_lat);
        end
        n_checks++;
        if ({obs_hi, obs_lo} !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++; $display("FAIL umax_product got %08h_%08h expected fffffffe_00000001", obs_hi, obs_lo);
        end
        n_checks++;
        if (busy_bad(34, 1'b0) !== 0) begin
            n_fail++; $display("FAIL umax_busy_profile mismatched cycles %0d expected 0", busy_bad(34, 1'b0));
        end
    endtask

    task automatic test_signed();
        do_mult(32'hFFFF_FFFD, 32'd7, 1'b1, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34 || {obs_hi, obs_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++; $display("FAIL signed_m3x7 got lat=%0d %08h_%08h expected lat=34 ffffffff_ffffffeb",
                               obs_lat, obs_hi, obs_lo);
        end
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34 || {obs_hi, obs_lo} !== 64'h4000_0000_0000_0000) begin
            n_fail++; $display("FAIL signed_minxmin got lat=%0d %08h_%08h expected lat=34 40000000_00000000",
                               obs_lat, obs_hi, obs_lo);
        end
    endtask

    task automatic test_back_to_back();
        do_mult(32'd7, 32'd8, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34 || obs_lo !== 32'd56) begin
            n_fail++; $display("FAIL b2b_first got lat=%0d lo=%0d expected lat=34 lo=56", obs_lat, obs_lo);
        end
        // Issued in the DONE cycle of the previous operation
        do_mult(32'd5, 32'd6, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34 || {obs_hi, obs_lo} !== 64'd30) begin
            n_fail++; $display("FAIL b2b_second got lat=%0d %08h_%08h expected lat=34 00000000_0000001e",
                               obs_lat, obs_hi, obs_lo);
        end
    endtask

    task automatic test_flush();
        do_mult(32'd11, 32'd13, 1'b0, 0, 0, 0, 40);
        do_mult(32'd2, 32'd3, 1'b0, 10, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 0) begin
            n_fail++; $display("FAIL flush_no_done got done at cycle %0d expected none", obs_lat);
        end
        n_checks++;
        if (busy_seen[10] !== 1'b1 || busy_seen[11] !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy got c10=%0b c11=%0b expected c10=1 c11=0",
                               busy_seen[10], busy_seen[11]);
        end
        n_checks++;
        if ({hi, lo} !== 64'd143) begin
            n_fail++; $display("FAIL flush_hold got %08h_%08h expected 00000000_0000008f", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        do_mult(32'd100, 32'd200, 1'b0, 0, 20, 0, 40);
        n_checks++;
        if (obs_lat !== 0 || busy_seen[21] !== 1'b0 || {busy, done, hi, lo} !== 66'd0) begin
            n_fail++; $display("FAIL reset_mid got lat=%0d busy21=%0b busy=%0b hi=%08h lo=%08h expected all zero",
                               obs_lat, busy_seen[21], busy, hi, lo);
        end
        do_mult(32'd100, 32'd200, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== 34 || {obs_hi, obs_lo} !== 64'd20000) begin
            n_fail++; $display("FAIL reset_recover got lat=%0d %08h_%08h expected lat=34 lo=00004e20",
                               obs_lat, obs_hi, obs_lo);
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] expv;
        expv = model(32'd1234, 32'd5678, 1'b0);
        do_mult(32'd1234, 32'd5678, 1'b0, 0, 0, 5, 40);
        n_checks++;
        if (obs_lat !== 34 || {obs_hi, obs_lo} !== expv) begin
            n_fail++; $display("FAIL ignored_start got lat=%0d %08h_%08h expected lat=34 %016h",
                               obs_lat, obs_hi, obs_lo, expv);
        end
    endtask

    task automatic test_zero();
        int el;
        el = exp_lat(32'd0, 32'h1234);
        do_mult(32'd0, 32'h1234, 1'b0, 0, 0, 0, 40);
        n_checks++;
        if (obs_lat !== el || {obs_hi, obs_lo} !== 64'd0) begin
            n_fail++; $display("FAIL zero_operand got lat=%0d %08h_%08h expected lat=%0d zero",
                               obs_lat, obs_hi, obs_lo, el);
        end
        n_checks++;
        if (busy_bad(el, el == 1) !== 0) begin
            n_fail++; $display("FAIL zero_busy mismatched cycles %0d expected 0", busy_bad(el, el == 1));
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic        s;
        logic [63:0] expv;
        int          el;
        for (int t = 0; t < 16; t++) begin
            x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
            if (t == 3) x = 32'd0;
            if (t == 7) y = 32'h8000_0000;
            if (t == 11) y = 32'd0;
            expv = model(x, y, s);
            el   = exp_lat(x, y);
            do_mult(x, y, s, 0, 0, 0, 40);
            n_checks++;
            if (obs_lat !== el || {obs_hi, obs_lo} !== expv) begin
                n_fail++; $display("FAIL random_%0d got lat=%0d %08h_%08h expected lat=%0d %016h",
                                   t, obs_lat, obs_hi, obs_lo, el, expv);
            end
            n_checks++;
            if (busy_bad(el, el == 1) !== 0) begin
                n_fail++; $display("FAIL random_busy_%0d mismatched cycles %0d expected 0",
                                   t, busy_bad(el, el == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_ignored_start();
        test_zero();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
